// File: rtl/neuron_memory_loader.sv
// Byte-stream loader: turns an (address, length, data...) host frame into external neuron memory writes.
// Optional trailing XOR checksum byte when NEURON_LOADER_CHECKSUM_EN is defined.
module neuron_memory_loader #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] neuron_read_address_ext,
    output logic [ADDR_WIDTH-1:0] neuron_write_address_ext,
    output logic [DATA_WIDTH-1:0] neuron_write_data_ext,
    output logic                  neuron_write_enable_ext,
    output logic                  select_external,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef NEURON_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_FLUSH, S_DONE} state_t;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_FLUSH, S_DONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         remaining_q, remaining_d;
    logic [TW-1:0]         idle_cnt_q, idle_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  sel_q, sel_d;
    logic                  err_q, err_d;
    logic                  accept, frame_wait, timeout;

    always_comb begin
        frame_wait = (state_q == S_LEN) || (state_q == S_DATA);
`ifdef NEURON_LOADER_CHECKSUM_EN
        frame_wait = frame_wait || (state_q == S_CSUM);
`endif
    end

    assign in_ready = (state_q == S_IDLE) || frame_wait;
    assign accept   = in_valid && in_ready;
    // Acceptance always wins over timeout: timeout needs in_valid low.
    assign timeout  = (IDLE_TIMEOUT != 0) && frame_wait && !in_valid && (idle_cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        sel_d       = sel_q;
        err_d       = err_q;
`ifdef NEURON_LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        idle_cnt_d  = (accept || !frame_wait) ? '0 : idle_cnt_q + 1'b1;

        case (state_q)
            S_IDLE: if (accept) begin
                addr_d  = ADDR_WIDTH'(in_data);
                sel_d   = 1'b1;
                err_d   = 1'b0;
`ifdef NEURON_LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
                state_d = S_LEN;
            end
            S_LEN: if (accept) begin
                remaining_d = (in_data == '0) ? FULL_LEN : CW'(in_data);
                state_d     = S_DATA;
            end
            S_DATA: if (accept) begin
                wr_addr_d   = addr_q;
                wr_data_d   = in_data;
                wr_en_d     = 1'b1;
                addr_d      = addr_q + 1'b1;
                remaining_d = remaining_q - 1'b1;
`ifdef NEURON_LOADER_CHECKSUM_EN
                csum_d      = csum_q ^ in_data;
                if (remaining_q == CW'(1)) state_d = S_CSUM;
`else
                if (remaining_q == CW'(1)) state_d = S_FLUSH;
`endif
            end
`ifdef NEURON_LOADER_CHECKSUM_EN
            S_CSUM: if (accept) begin
                // Writes are already committed; a bad checksum only flags the frame.
                if (in_data == csum_q) begin
                    state_d = S_FLUSH;
                end else begin
                    err_d   = 1'b1;
                    sel_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
`endif
            S_FLUSH: state_d = S_DONE;
            S_DONE: begin
                sel_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            err_d   = 1'b1;
            sel_d   = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            idle_cnt_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            sel_q       <= 1'b0;
            err_q       <= 1'b0;
`ifdef NEURON_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            idle_cnt_q  <= idle_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            sel_q       <= sel_d;
            err_q       <= err_d;
`ifdef NEURON_LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign neuron_read_address_ext  = '0;
    assign neuron_write_address_ext = wr_addr_q;
    assign neuron_write_data_ext    = wr_data_q;
    assign neuron_write_enable_ext  = wr_en_q;
    assign select_external          = sel_q;
    assign busy                     = (state_q != S_IDLE);
    assign done                     = (state_q == S_DONE);
    assign error                    = err_q;
endmodule

// File: tb/tb_neuron_memory_loader.sv
// Scoreboard bench for neuron_memory_loader: stimulus pushes expected writes/done pulses,
// a negedge monitor pops and compares them. Exercises the checksum path when NEURON_LOADER_CHECKSUM_EN is set.
module tb_neuron_memory_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rd_addr, wr_addr, wr_data;
    logic       wr_en, sel_ext, busy, done, error;

    neuron_memory_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .IDLE_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .neuron_read_address_ext(rd_addr), .neuron_write_address_ext(wr_addr),
        .neuron_write_data_ext(wr_data), .neuron_write_enable_ext(wr_en),
        .select_external(sel_ext), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    int         exp_done = 0;
    int         checks   = 0;
    int         errors   = 0;
    logic [7:0] cur_addr;
    logic [7:0] csum_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every write strobe and done pulse against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %0h/%0h expected none at %0t", wr_addr, wr_data, $time);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (wr_addr !== e.a || wr_data !== e.d) begin
                        errors++;
                        $display("FAIL write: got %0h/%0h expected %0h/%0h at %0t", wr_addr, wr_data, e.a, e.d, $time);
                    end
                end
                chk("sel_during_write", sel_ext, 1);
            end
            if (done) begin
                checks++;
                if (exp_done == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
                end else begin
                    exp_done--;
                end
            end
        end
    end

    // All tasks start and end 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got in_ready=0 expected 1 at %0t", $time);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] a, input logic [7:0] len);
        send_byte(a);
        send_byte(len);
        cur_addr = a;
        csum_acc = 8'h00;
    endtask

    task automatic data_byte(input logic [7:0] d);
        wr_t e;
        e.a = cur_addr;
        e.d = d;
        exp_q.push_back(e);
        cur_addr = cur_addr + 8'd1;
        csum_acc = csum_acc ^ d;
        send_byte(d);
    endtask

    task automatic end_frame_ok();
        exp_done++;
`ifdef NEURON_LOADER_CHECKSUM_EN
        send_byte(csum_acc);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_sel", sel_ext, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rd_addr", rd_addr, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-DATA: second write is in flight and must be dropped.
        start_frame(8'h40, 8'd5);
        data_byte(8'hE0);
        send_byte(8'hE1);
        chk("inflight_strobe", wr_en, 1);
        #1 rst = 1'b1;
        #1;
        chk("amid_in_ready", in_ready, 1);
        chk("amid_wr_en", wr_en, 0);
        chk("amid_wr_addr", wr_addr, 0);
        chk("amid_wr_data", wr_data, 0);
        chk("amid_sel", sel_ext, 0);
        chk("amid_busy", busy, 0);
        chk("amid_done", done, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frame: writes on consecutive cycles, done two edges after the last accept.
        start_frame(8'h10, 8'd3);
        data_byte(8'hA1);
        chk("t_wr0_en", wr_en, 1);
        data_byte(8'hB2);
        chk("t_wr1_addr", wr_addr, 8'h11);
        data_byte(8'hC3);
        chk("t_wr2_en", wr_en, 1);
        chk("t_wr2_addr", wr_addr, 8'h12);
        chk("t_wr2_data", wr_data, 8'hC3);
        end_frame_ok();
        chk("flush_busy", busy, 1);
        chk("flush_sel", sel_ext, 1);
        chk("flush_done", done, 0);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 1);
        chk("done_sel", sel_ext, 1);
        chk("done_wr_en", wr_en, 0);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("post_sel", sel_ext, 0);
        chk("post_busy", busy, 0);
        chk("hold_addr", wr_addr, 8'h12);
        chk("hold_data", wr_data, 8'hC3);

        // len=0 means 256 bytes; address wraps, gaps stay under the timeout.
        start_frame(8'hFE, 8'd0);
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 5));
            data_byte(8'(i) ^ 8'h5A);
        end
        end_frame_ok();
        idle_cycles(4);
        chk("wrap_error", error, 0);
        chk("wrap_busy", busy, 0);

        // Idle timeout after two of four data bytes.
        start_frame(8'h20, 8'd4);
        data_byte(8'hD0);
        data_byte(8'hD1);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("to7_error", error, 0);
        chk("to7_sel", sel_ext, 1);
        chk("to7_busy", busy, 1);
        @(posedge clk); #1;
        chk("to8_error", error, 1);
        chk("to8_sel", sel_ext, 0);
        chk("to8_busy", busy, 0);
        chk("to8_done", done, 0);
        idle_cycles(3);
        chk("to_sticky", error, 1);

`ifdef NEURON_LOADER_CHECKSUM_EN
        start_frame(8'h60, 8'd3);
        data_byte(8'h01); data_byte(8'h02); data_byte(8'h04);
        chk("csum_value", csum_acc, 8'h07);
        end_frame_ok();
        idle_cycles(3);
        chk("csum_ok_error", error, 0);

        start_frame(8'h70, 8'd3);
        data_byte(8'h01); data_byte(8'h02); data_byte(8'h04);
        send_byte(8'h06);
        chk("csum_bad_error", error, 1);
        chk("csum_bad_busy", busy, 0);
        chk("csum_bad_sel", sel_ext, 0);
        idle_cycles(3);
        chk("csum_bad_done", done, 0);
`endif

        // Next address byte held across FLUSH/DONE; also clears the sticky error.
        send_byte(8'h30);
        chk("err_cleared", error, 0);
        send_byte(8'd2);
        cur_addr = 8'h30; csum_acc = 8'h00;
        data_byte(8'h11);
        data_byte(8'h22);
        end_frame_ok();
        in_data = 8'h50; in_valid = 1'b1;
        chk("hold_flush_ready", in_ready, 0);
        @(posedge clk); #1;
        chk("hold_done_ready", in_ready, 0);
        chk("hold_done_pulse", done, 1);
        @(posedge clk); #1;
        chk("hold_idle_ready", in_ready, 1);
        chk("hold_idle_sel", sel_ext, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("hold_acc_busy", busy, 1);
        chk("hold_acc_sel", sel_ext, 1);
        send_byte(8'd1);
        cur_addr = 8'h50; csum_acc = 8'h00;
        data_byte(8'h55);
        end_frame_ok();
        idle_cycles(5);

        chk("exp_writes_left", exp_q.size(), 0);
        chk("exp_done_left", exp_done, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
